// File: rtl/sm4_key_expand.sv
`default_nettype none
// ============================================================================
// Module   : sm4_key_expand
// Purpose  : SM4 key schedule producing rk0..rk31, one round key per clock.
// Revision : 1.0
// ============================================================================
module sm4_key_expand (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_start_in,
    input  logic [127:0] key_in,
    output logic [4:0]   count_round_out,
    input  logic [31:0]  cki_in,
    output logic [31:0]  rk_out,
    output logic         rk_valid_out,
    output logic [4:0]   rk_index_out,
    output logic         key_ready_out,
    output logic         key_done_out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [127:0] c_fk = 128'ha3b1bac6_56aa3350_677d9197_b27022dc;

    localparam logic [2047:0] c_sbox = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    function automatic logic [7:0] sbox_lu(input logic [7:0] a);
        logic [10:0] base;
        base = 11'd2047 - {a, 3'b000};
        return c_sbox[base -: 8];
    endfunction

    state_t      r_state_q, w_state_d;
    logic [4:0]  r_ctr_q, w_ctr_d;
    logic [31:0] r_k0_q, r_k1_q, r_k2_q, r_k3_q;
    logic [31:0] w_k0_d, w_k1_d, w_k2_d, w_k3_d;
    logic [31:0] r_rk_q, w_rk_d;
    logic        r_valid_q, w_valid_d;
    logic [4:0]  r_idx_q, w_idx_d;
    logic        r_done_q, w_done_d;

    logic [31:0] w_x, w_b, w_tp, w_rk;

    // Round function: non-linear tau followed by the key-schedule linear map L'.
    assign w_x  = r_k1_q ^ r_k2_q ^ r_k3_q ^ cki_in;
    assign w_b  = {sbox_lu(w_x[31:24]), sbox_lu(w_x[23:16]),
                   sbox_lu(w_x[15:8]),  sbox_lu(w_x[7:0])};
    assign w_tp = w_b ^ {w_b[18:0], w_b[31:19]} ^ {w_b[8:0], w_b[31:9]};
    assign w_rk = r_k0_q ^ w_tp;

    always_comb begin
        w_state_d = r_state_q;
        w_ctr_d   = r_ctr_q;
        w_k0_d    = r_k0_q;
        w_k1_d    = r_k1_q;
        w_k2_d    = r_k2_q;
        w_k3_d    = r_k3_q;
        w_rk_d    = r_rk_q;
        w_valid_d = r_valid_q;
        w_idx_d   = r_idx_q;
        w_done_d  = r_done_q;
        case (r_state_q)
            S_IDLE: begin
                if (key_start_in) begin
                    {w_k0_d, w_k1_d, w_k2_d, w_k3_d} = key_in ^ c_fk;
                    w_ctr_d   = 5'd0;
                    w_state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                w_rk_d    = w_rk;
                w_valid_d = 1'b1;
                w_idx_d   = r_ctr_q;
                w_k0_d    = r_k1_q;
                w_k1_d    = r_k2_q;
                w_k2_d    = r_k3_q;
                w_k3_d    = w_rk;
                // Counter is parked at 0 after the last round so the CK address idles at 0.
                if (r_ctr_q == 5'd31) begin
                    w_ctr_d   = 5'd0;
                    w_done_d  = 1'b1;
                    w_state_d = S_DONE;
                end else begin
                    w_ctr_d = r_ctr_q + 5'd1;
                end
            end
            S_DONE: begin
                w_valid_d = 1'b0;
                w_done_d  = 1'b0;
                w_state_d = S_IDLE;
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= S_IDLE;
            r_ctr_q   <= 5'd0;
            r_k0_q    <= 32'd0;
            r_k1_q    <= 32'd0;
            r_k2_q    <= 32'd0;
            r_k3_q    <= 32'd0;
            r_rk_q    <= 32'd0;
            r_valid_q <= 1'b0;
            r_idx_q   <= 5'd0;
            r_done_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_ctr_q   <= w_ctr_d;
            r_k0_q    <= w_k0_d;
            r_k1_q    <= w_k1_d;
            r_k2_q    <= w_k2_d;
            r_k3_q    <= w_k3_d;
            r_rk_q    <= w_rk_d;
            r_valid_q <= w_valid_d;
            r_idx_q   <= w_idx_d;
            r_done_q  <= w_done_d;
        end
    end

    assign count_round_out = r_ctr_q;
    assign rk_out          = r_rk_q;
    assign rk_valid_out    = r_valid_q;
    assign rk_index_out    = r_idx_q;
    assign key_done_out    = r_done_q;
    assign key_ready_out   = (r_state_q == S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sm4_key_expand.sv
`default_nettype none
// ============================================================================
// Module   : tb_sm4_key_expand
// Purpose  : Self-checking bench for sm4_key_expand against a key-schedule model.
// Revision : 1.0
// ============================================================================
module tb_sm4_key_expand;

    localparam logic [127:0] STD_KEY = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] FK      = 128'ha3b1bac6_56aa3350_677d9197_b27022dc;

    localparam logic [127:0] SBOX_ROWS [16] = '{
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         key_start_in = 1'b0;
    logic [127:0] key_in = '0;
    logic [4:0]   count_round_out;
    logic [31:0]  cki_in;
    logic [31:0]  rk_out;
    logic         rk_valid_out;
    logic [4:0]   rk_index_out;
    logic         key_ready_out;
    logic         key_done_out;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_rk [32];

    sm4_key_expand dut (
        .clk             (clk),
        .rst             (rst),
        .key_start_in    (key_start_in),
        .key_in          (key_in),
        .count_round_out (count_round_out),
        .cki_in          (cki_in),
        .rk_out          (rk_out),
        .rk_valid_out    (rk_valid_out),
        .rk_index_out    (rk_index_out),
        .key_ready_out   (key_ready_out),
        .key_done_out    (key_done_out)
    );

    always #5 clk = ~clk;

    // CK table: byte j of CK_i is (4i+j)*7 mod 256.
    function automatic logic [31:0] ck_word(input int i);
        logic [31:0] w;
        for (int j = 0; j < 4; j++) w[31-8*j -: 8] = 8'(((4 * i + j) * 7) % 256);
        return w;
    endfunction

    assign cki_in = ck_word(int'(count_round_out));

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [127:0] row;
        row = SBOX_ROWS[a[7:4]];
        return row[127 - 8 * int'(a[3:0]) -: 8];
    endfunction

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] t_prime(input logic [31:0] x);
        logic [31:0] b;
        for (int j = 0; j < 4; j++) b[8*j +: 8] = sbox(x[8*j +: 8]);
        return b ^ rotl(b, 13) ^ rotl(b, 23);
    endfunction

    task automatic model_expand(input logic [127:0] mk);
        logic [31:0] k [36];
        for (int j = 0; j < 4; j++) k[j] = mk[127-32*j -: 32] ^ FK[127-32*j -: 32];
        for (int i = 0; i < 32; i++) begin
            k[i+4]    = k[i] ^ t_prime(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck_word(i));
            exp_rk[i] = k[i+4];
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check_val({tag, "_rk"},    rk_out, 32'd0);
        check_val({tag, "_valid"}, 32'(rk_valid_out), 32'd0);
        check_val({tag, "_idx"},   32'(rk_index_out), 32'd0);
        check_val({tag, "_done"},  32'(key_done_out), 32'd0);
        check_val({tag, "_ready"}, 32'(key_ready_out), 32'd1);
        check_val({tag, "_count"}, 32'(count_round_out), 32'd0);
    endtask

    // One expansion from start edge E0 through E33; busy holds start high and
    // scrambles key_in; abort_at < 32 resets just before edge E(abort_at+1).
    task automatic run_expand(input logic [127:0] key, input bit busy, input int abort_at);
        model_expand(key);
        @(negedge clk);
        key_in       = key;
        key_start_in = 1'b1;
        @(posedge clk); #1;
        if (!busy) key_start_in = 1'b0;
        check_val("e0_ready", 32'(key_ready_out), 32'd0);
        check_val("e0_valid", 32'(rk_valid_out), 32'd0);
        check_val("e0_count", 32'(count_round_out), 32'd0);
        for (int i = 0; i < 32; i++) begin
            if (busy) key_in = {$urandom, $urandom, $urandom, $urandom};
            if (i == abort_at) begin
                @(negedge clk) rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                check_idle_zero("abort");
                for (int c = 0; c < 3; c++) begin
                    @(posedge clk); #1;
                    check_val($sformatf("post_abort_valid%0d", c), 32'(rk_valid_out), 32'd0);
                    check_val($sformatf("post_abort_done%0d", c), 32'(key_done_out), 32'd0);
                end
                return;
            end
            @(posedge clk); #1;
            check_val($sformatf("rk%0d", i), rk_out, exp_rk[i]);
            check_val($sformatf("valid%0d", i), 32'(rk_valid_out), 32'd1);
            check_val($sformatf("idx%0d", i), 32'(rk_index_out), 32'(i));
            check_val($sformatf("done%0d", i), 32'(key_done_out), (i == 31) ? 32'd1 : 32'd0);
            check_val($sformatf("ready%0d", i), 32'(key_ready_out), 32'd0);
            check_val($sformatf("count%0d", i), 32'(count_round_out), (i == 31) ? 32'd0 : 32'(i + 1));
            if (key == STD_KEY && i == 0)  check_val("std_rk0", rk_out, 32'hf12186f9);
            if (key == STD_KEY && i == 1)  check_val("std_rk1", rk_out, 32'h41662b61);
            if (key == STD_KEY && i == 31) check_val("std_rk31", rk_out, 32'h9124a012);
        end
        @(posedge clk); #1;
        check_val("e33_valid", 32'(rk_valid_out), 32'd0);
        check_val("e33_done",  32'(key_done_out), 32'd0);
        check_val("e33_ready", 32'(key_ready_out), 32'd1);
        check_val("e33_rk",    rk_out, exp_rk[31]);
        check_val("e33_idx",   32'(rk_index_out), 32'd31);
        check_val("e33_count", 32'(count_round_out), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_idle_zero("reset");
        rst = 1'b0;

        run_expand(STD_KEY, 1'b0, 99);
        run_expand(STD_KEY, 1'b1, 99);
        run_expand(STD_KEY, 1'b0, 99);
        run_expand(STD_KEY, 1'b0, 10);
        run_expand(STD_KEY, 1'b0, 99);

        @(negedge clk);
        rst          = 1'b1;
        key_start_in = 1'b1;
        key_in       = STD_KEY;
        @(posedge clk); #1;
        rst          = 1'b0;
        key_start_in = 1'b0;
        check_idle_zero("rst_prio");
        @(posedge clk); #1;
        check_val("rst_prio_ready2", 32'(key_ready_out), 32'd1);
        check_val("rst_prio_valid2", 32'(rk_valid_out), 32'd0);

        run_expand(128'd0, 1'b0, 99);

        for (int r = 0; r < 4; r++) begin
            run_expand({$urandom, $urandom, $urandom, $urandom},
                       (r == 3) ? 1'b0 : 1'($urandom_range(0, 1)), 99);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
